signed_accumulator: RTL and testbench
=====================================

Name: signed_accumulator

Overview:
- Parametrised clocked successor to the lab calculator accumulator: a signed two's-complement running accumulator driven by an "equal" button.
- Each button press applies one operation (add, subtract, load, clear) of the N-bit input to the accumulator.
- Flags signed overflow.
- Presents sign-magnitude outputs for the seven-segment display path and counts operations since the last clear.

Parameters:
- N, 4, data width in bits (two's complement); N >= 2.
- CNT_W, 4, width of the operation counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- equal  input  1  press request, level. Already debounced and synchronised upstream.
- op  input  2  operation: 00 add, 01 subtract, 10 load, 11 clear.
- number  input  N  signed operand.
- sum  output  N  signed accumulator value.
- SSD  output  N  unsigned magnitude |sum|.
- sign  output  1  1 when sum is negative.
- c_out  output  1  signed overflow of the last operation.
- done  output  1  one-cycle pulse when an operation commits.
- op_cnt  output  CNT_W  number of committed ops since reset or clear; saturates at all-ones.

Behaviour:
- Reset (rst_n=0, asynchronous): sum, SSD, sign, c_out, done and op_cnt are 0; internal equal_d is 0; state is EMPTY. All outputs are registered.
- Press detection: press = equal & ~equal_d, where equal_d is equal registered every clk.
  - Holding equal high for any number of cycles gives exactly one press.
  - A new press needs equal to go low for at least one clk first.
- Latency: the operation commits on the rising edge that first samples equal=1. All outputs are valid immediately after that edge, and done is high for exactly that following cycle.
- States:
  - EMPTY: no operand entered yet.
  - ACC: accumulating.
- Commit rules, EMPTY with press:
  - op 00, 01 or 10: sum<=number, c_out<=0, state<=ACC.
  - op 11: sum<=0, c_out<=0, stay EMPTY.
- Commit rules, ACC with press:
  - op 00: sum<=sum+number. c_out=1 iff the operand MSBs are equal and the result MSB differs.
  - op 01: sum<=sum-number. c_out=1 iff the operand MSBs differ and the result MSB differs from sum's MSB.
  - op 10: sum<=number, c_out<=0.
  - op 11: sum<=0, c_out<=0, state<=EMPTY.
- Arithmetic: computed in N+1 bits and truncated to N, so the default result wraps modulo 2^N.
- c_out is per-operation, not sticky. It holds its value until the next commit.
- op_cnt:
  - Increments on every committed op except clear.
  - Clear sets it to 0.
  - Stops at 2^CNT_W-1.
- SSD and sign are derived from the committed sum and registered together with it:
  - sign = sum[N-1].
  - SSD = sign ? (~sum+1) : sum, taken as N-bit unsigned.
  - Most-negative value: sum=100..0 gives SSD=100..0, i.e. 2^(N-1) (8 for N=4), sign=1.
- Between presses, changes on number or op have no effect on any output.
- Reset asserted during a press cycle: reset wins, outputs go to 0 and state to EMPTY. After rst_n rises with equal still high, no press is detected until equal has been low for at least one clk.

Optional Feature:
- Macro: ACCUM_SATURATE_EN.
- Defined: on overflow, sum clamps to the extreme value instead of wrapping. Positive overflow gives 2^(N-1)-1; negative overflow gives -2^(N-1). c_out is still 1 for that op.
- Undefined: wrap-around modulo 2^N as described in Behaviour.

Test Plan:
1. Reset, then press with op=00, number=3 -> sum=3, SSD=3, sign=0, c_out=0, op_cnt=1, done pulse of 1 cycle.
2. From sum=3, press op=00 with number=6 -> sum=1001 (-7), sign=1, SSD=7, c_out=1. With ACCUM_SATURATE_EN: sum=0111, SSD=7, sign=0, c_out=1.
3. Press op=10 with number=1000, then op=01 with number=1 -> after the first press sum=-8, SSD=8, sign=1; after the second, wrap gives sum=0111, c_out=1. With ACCUM_SATURATE_EN: sum=1000.
4. From sum=5, press op=11, then op=00 with number=2 -> after clear sum=0, op_cnt=0, state EMPTY; the next add loads, so sum=2, op_cnt=1.
5. Hold equal high for 10 cycles with op=00, number=1, starting from sum=0 in ACC -> exactly one commit: sum=1, done high for 1 cycle only.
6. Assert rst_n low mid-cycle while sum=6 and equal is high -> all outputs 0 immediately, without waiting for clk. Release rst_n with equal still high -> no commit until equal has gone low and then high again.

Source files
------------

// File: rtl/signed_accumulator.sv
// rtl/signed_accumulator.sv - signed running accumulator committed by a debounced "equal" press.
// Build option: ACCUM_SATURATE_EN clamps overflowing results instead of wrapping.
module signed_accumulator #(
  parameter int N     = 4,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             equal,
  input  logic [1:0]       op,
  input  logic [N-1:0]     number,
  output logic [N-1:0]     sum,
  output logic [N-1:0]     SSD,
  output logic             sign,
  output logic             c_out,
  output logic             done,
  output logic [CNT_W-1:0] op_cnt
);

  typedef enum logic {EMPTY = 1'b0, ACC = 1'b1} state_t;

  localparam logic [N-1:0]     SUM_ONE = {{(N-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
`ifdef ACCUM_SATURATE_EN
  localparam logic [N-1:0] SUM_MAX = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0] SUM_MIN = {1'b1, {(N-1){1'b0}}};
`endif

  state_t           state_q, state_d;
  logic [N-1:0]     sum_q, sum_d;
  logic [N-1:0]     ssd_q, ssd_d;
  logic             sign_q, sign_d;
  logic             c_q, c_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             equal_prev_q, equal_prev_d;
  logic             armed_q, armed_d;

  logic             press;
  logic [N:0]       add_ext, sub_ext;
  logic             add_ovf, sub_ovf;

  // armed_q blocks a press after reset until equal has been seen low once
  assign press   = equal & ~equal_prev_q & armed_q;
  assign add_ext = {sum_q[N-1], sum_q} + {number[N-1], number};
  assign sub_ext = {sum_q[N-1], sum_q} - {number[N-1], number};
  assign add_ovf = add_ext[N] ^ add_ext[N-1];
  assign sub_ovf = sub_ext[N] ^ sub_ext[N-1];

  always_comb begin
    state_d      = state_q;
    sum_d        = sum_q;
    c_d          = c_q;
    cnt_d        = cnt_q;
    done_d       = press;
    equal_prev_d = equal;
    armed_d      = armed_q | ~equal;

    if (press) begin
      if (op == 2'b11) begin
        sum_d   = '0;
        c_d     = 1'b0;
        cnt_d   = '0;
        state_d = EMPTY;
      end else begin
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_ONE;
        if (state_q == EMPTY || op == 2'b10) begin
          sum_d   = number;
          c_d     = 1'b0;
          state_d = ACC;
        end else begin
          if (op == 2'b00) begin
            sum_d = add_ext[N-1:0];
            c_d   = add_ovf;
          end else begin
            sum_d = sub_ext[N-1:0];
            c_d   = sub_ovf;
          end
`ifdef ACCUM_SATURATE_EN
          // overflow direction always follows the sign of the old accumulator
          if (c_d) sum_d = sum_q[N-1] ? SUM_MIN : SUM_MAX;
`endif
        end
      end
    end

    sign_d = sum_d[N-1];
    ssd_d  = sign_d ? (~sum_d + SUM_ONE) : sum_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= EMPTY;
      sum_q        <= '0;
      ssd_q        <= '0;
      sign_q       <= 1'b0;
      c_q          <= 1'b0;
      done_q       <= 1'b0;
      cnt_q        <= '0;
      equal_prev_q <= 1'b0;
      armed_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      sum_q        <= sum_d;
      ssd_q        <= ssd_d;
      sign_q       <= sign_d;
      c_q          <= c_d;
      done_q       <= done_d;
      cnt_q        <= cnt_d;
      equal_prev_q <= equal_prev_d;
      armed_q      <= armed_d;
    end
  end

  assign sum    = sum_q;
  assign SSD    = ssd_q;
  assign sign   = sign_q;
  assign c_out  = c_q;
  assign done   = done_q;
  assign op_cnt = cnt_q;

endmodule

// File: tb/tb_signed_accumulator.sv
// tb/tb_signed_accumulator.sv - self-checking bench for signed_accumulator.
module tb_signed_accumulator;
  localparam int N       = 4;
  localparam int CNT_W   = 4;
  localparam int MAXV    = 7;
  localparam int MINV    = -8;
  localparam int CNT_SAT = 15;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             equal = 1'b0;
  logic [1:0]       op = 2'b00;
  logic [N-1:0]     number = '0;
  logic [N-1:0]     sum, SSD;
  logic             sign, c_out, done;
  logic [CNT_W-1:0] op_cnt;

  signed_accumulator #(.N(N), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .equal(equal), .op(op), .number(number),
    .sum(sum), .SSD(SSD), .sign(sign), .c_out(c_out), .done(done), .op_cnt(op_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  int m_sum, m_c, m_cnt, m_done;
  bit m_empty, m_prev_eq;

  typedef struct {
    int o;
    int n;
    int e_wrap;
    int e_sat;
    int e_c;
    int e_cnt;
  } vec_t;
  vec_t tbl[9];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    m_sum = 0; m_c = 0; m_cnt = 0; m_done = 0;
    m_empty = 1'b1;
    m_prev_eq = 1'b1;
  endfunction

  function automatic void model_apply(input int o, input int n);
    int r;
    if (o == 3) begin
      m_sum = 0; m_c = 0; m_cnt = 0; m_empty = 1'b1;
    end else begin
      if (m_cnt < CNT_SAT) m_cnt++;
      if (m_empty || o == 2) begin
        m_sum = n; m_c = 0; m_empty = 1'b0;
      end else begin
        r = (o == 0) ? m_sum + n : m_sum - n;
        m_c = (r > MAXV || r < MINV) ? 1 : 0;
`ifdef ACCUM_SATURATE_EN
        if (r > MAXV) r = MAXV;
        if (r < MINV) r = MINV;
`else
        if (r > MAXV) r = r - (1 << N);
        if (r < MINV) r = r + (1 << N);
`endif
        m_sum = r;
      end
    end
  endfunction

  task automatic check_outs(input string tag);
    check({tag, " sum"}, $signed(sum), m_sum);
    check({tag, " SSD"}, SSD, (m_sum < 0) ? -m_sum : m_sum);
    check({tag, " sign"}, sign, (m_sum < 0) ? 1 : 0);
    check({tag, " c_out"}, c_out, m_c);
    check({tag, " op_cnt"}, op_cnt, m_cnt);
    check({tag, " done"}, done, m_done);
  endtask

  // called at a falling edge; drives inputs for the next rising edge, then checks
  task automatic tick(input bit eq, input int o, input int n, input string tag);
    equal  = eq;
    op     = o[1:0];
    number = n[N-1:0];
    m_done = 0;
    if (eq && !m_prev_eq) begin
      model_apply(o, n);
      m_done = 1;
    end
    m_prev_eq = eq;
    @(negedge clk);
    check_outs(tag);
  endtask

  task automatic do_reset();
    equal = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    check("reset sum", sum, 0);
    check("reset SSD", SSD, 0);
    check("reset sign", sign, 0);
    check("reset c_out", c_out, 0);
    check("reset done", done, 0);
    check("reset op_cnt", op_cnt, 0);
    rst_n = 1'b1;
    model_reset();
    tick(1'b0, 0, 0, "post_reset");
  endtask

  initial begin
    int exp_sum, dones, o, n;

    tbl[0] = '{o: 0, n:  3, e_wrap:  3, e_sat:  3, e_c: 0, e_cnt: 1};
    tbl[1] = '{o: 0, n:  6, e_wrap: -7, e_sat:  7, e_c: 1, e_cnt: 2};
    tbl[2] = '{o: 2, n: -8, e_wrap: -8, e_sat: -8, e_c: 0, e_cnt: 3};
    tbl[3] = '{o: 1, n:  1, e_wrap:  7, e_sat: -8, e_c: 1, e_cnt: 4};
    tbl[4] = '{o: 2, n:  5, e_wrap:  5, e_sat:  5, e_c: 0, e_cnt: 5};
    tbl[5] = '{o: 3, n:  0, e_wrap:  0, e_sat:  0, e_c: 0, e_cnt: 0};
    tbl[6] = '{o: 0, n:  2, e_wrap:  2, e_sat:  2, e_c: 0, e_cnt: 1};
    tbl[7] = '{o: 1, n: -8, e_wrap: -6, e_sat:  7, e_c: 1, e_cnt: 2};
    tbl[8] = '{o: 3, n:  0, e_wrap:  0, e_sat:  0, e_c: 0, e_cnt: 0};

    do_reset();

    for (int i = 0; i < 9; i++) begin
      tick(1'b1, tbl[i].o, tbl[i].n, $sformatf("tbl%0d", i));
`ifdef ACCUM_SATURATE_EN
      exp_sum = tbl[i].e_sat;
`else
      exp_sum = tbl[i].e_wrap;
`endif
      check($sformatf("tbl%0d const sum", i), $signed(sum), exp_sum);
      check($sformatf("tbl%0d const c_out", i), c_out, tbl[i].e_c);
      check($sformatf("tbl%0d const op_cnt", i), op_cnt, tbl[i].e_cnt);
      check($sformatf("tbl%0d const done", i), done, 1);
      tick(1'b0, 0, 5, $sformatf("tbl%0d gap", i));
      check($sformatf("tbl%0d done low", i), done, 0);
    end

    // clear in EMPTY stays EMPTY: following add must load
    tick(1'b1, 3, 0, "empty_clear");
    tick(1'b0, 0, 0, "empty_clear gap");
    tick(1'b1, 1, 3, "empty_sub_loads");
    check("empty_sub_loads const", $signed(sum), 3);
    tick(1'b0, 0, 0, "gap");

    // long hold gives exactly one commit
    tick(1'b1, 2, 0, "hold_load0");
    tick(1'b0, 0, 0, "hold gap");
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1'b1, 0, 1, "hold");
      dones += int'(done);
    end
    check("hold done count", dones, 1);
    check("hold sum", $signed(sum), 1);
    tick(1'b0, 0, 0, "hold release");

    // op counter saturation
    tick(1'b1, 3, 0, "cnt_clear");
    tick(1'b0, 0, 0, "cnt gap");
    for (int i = 0; i < 18; i++) begin
      tick(1'b1, 0, 1, "cnt_add");
      tick(1'b0, 3, 0, "cnt gap");
    end
    check("cnt saturated", op_cnt, CNT_SAT);

    // asynchronous reset in the middle of a press cycle
    tick(1'b1, 2, 6, "pre_reset_load");
    tick(1'b0, 0, 0, "pre_reset gap");
    equal  = 1'b1;
    op     = 2'b00;
    number = 4'd1;
    #2 rst_n = 1'b0;
    #1;
    check("async sum", sum, 0);
    check("async SSD", SSD, 0);
    check("async sign", sign, 0);
    check("async c_out", c_out, 0);
    check("async done", done, 0);
    check("async op_cnt", op_cnt, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) tick(1'b1, 0, 1, "held_after_reset");
    check("held_after_reset no done", done, 0);
    tick(1'b0, 0, 1, "rearm");
    tick(1'b1, 0, 4, "first_after_reset");
    check("first_after_reset sum", $signed(sum), 4);
    check("first_after_reset done", done, 1);

    // randomized run against the reference model
    do_reset();
    for (int i = 0; i < 600; i++) begin
      o = ($urandom_range(0, 15) == 0) ? 3 : int'($urandom_range(0, 2));
      n = int'($urandom_range(0, 15)) - 8;
      tick($urandom_range(0, 1) == 1, o, n, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
